// File: rtl/sr_trace_monitor_if.sv
// sr_trace_monitor_if
// Retire-stream bundle between the schoolRISCV core (or a bench) and the
// run monitor.
//   valid    : core advanced this cycle (core clock enable)
//   pc       : current program counter
//   instr    : current instruction word
//   reg_data : value of the watched result register (normally a0)
// The master modport drives the stream and the slave modport observes it.
interface sr_trace_monitor_if;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] reg_data;

    modport master (output valid, output pc, output instr, output reg_data);
    modport slave  (input  valid, input  pc, input  instr, input  reg_data);
endinterface

// File: rtl/sr_trace_monitor.sv
// sr_trace_monitor
// Hardware run monitor for the schoolRISCV core. It counts valid cycles and
// branches, detects program halt as a pc that stays put for HALT_REPEAT valid
// cycles, and checks the watched register against an expected value. If the
// program never halts, it raises TIMEOUT. It also keeps a circular trace of
// the last TRACE_DEPTH distinct pcs for readback.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start             : begin a run (ignored while running)
//   expect_en/_val    : result check enable and value, latched with start
//   cpu               : retire stream (valid, pc, instr, reg_data)
//   state, done       : 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT; done = terminal
//   cycle_cnt         : valid cycles in the current or last run
//   branch_cnt        : valid cycles carrying a branch opcode
//   result            : reg_data captured on the halting cycle
//   trace_idx         : readback index, 0 = most recent entry
//   trace_pc/_instr   : selected trace entry (0 when beyond trace_count)
//   trace_count       : number of valid trace entries, saturating
module sr_trace_monitor #(
    parameter int TIMEOUT_CYCLES = 120,
    parameter int HALT_REPEAT    = 4,
    parameter int TRACE_DEPTH    = 8,
    parameter int TW             = $clog2(TRACE_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                expect_en,
    input  logic [31:0]         expect_val,
    sr_trace_monitor_if.slave   cpu,
    output logic [2:0]          state,
    output logic                done,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         result,
    input  logic [TW-1:0]       trace_idx,
    output logic [31:0]         trace_pc,
    output logic [31:0]         trace_instr,
    output logic [TW:0]         trace_count
);

    localparam int SW = $clog2(HALT_REPEAT + 1);
    localparam logic [SW-1:0] HALT_MAX    = SW'(HALT_REPEAT);
    localparam logic [31:0]   TO_LIMIT    = 32'(TIMEOUT_CYCLES);
    localparam logic [TW:0]   DEPTH_MAX   = (TW+1)'(TRACE_DEPTH);
    localparam logic [6:0]    OPC_BRANCH  = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic            exp_en_q;
    logic [31:0]     exp_val_q;
    logic [SW-1:0]   stable_cnt;
    logic            seen_q;
    logic [31:0]     last_pc;
    logic [TW-1:0]   wr_ptr;

    logic [31:0]     mem_pc    [TRACE_DEPTH];
    logic [31:0]     mem_instr [TRACE_DEPTH];

    logic            start_ok;
    logic            sample;
    logic            new_pc;
    logic [SW-1:0]   stable_next;
    logic [31:0]     cycle_next;
    logic            halt;
    logic            timeout;
    logic [TW-1:0]   rd_ptr;

    // Per-cycle decisions derived from the current sample. The stable counter
    // restarts at 1 on every pc change and on the very first sample of a run.
    always_comb begin
        start_ok    = start && (state_q != S_RUN);
        sample      = (state_q == S_RUN) && cpu.valid;
        new_pc      = !seen_q || (cpu.pc != last_pc);
        stable_next = new_pc ? SW'(1)
                    : ((stable_cnt == HALT_MAX) ? HALT_MAX : stable_cnt + SW'(1));
        cycle_next  = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;
        halt        = sample && (stable_next == HALT_MAX);
        timeout     = sample && !halt && (cycle_next == TO_LIMIT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; halt takes priority over a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (halt) begin
                    state_d = (!exp_en_q || (cpu.reg_data == exp_val_q)) ? S_PASS : S_FAIL;
                end else if (timeout) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        done = 1'b0;
        case (state_q)
            S_PASS, S_FAIL, S_TIMEOUT: done = 1'b1;
            default:                   done = 1'b0;
        endcase
    end

    assign state = state_q;

    // Counters, streak tracking, result capture and trace bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_en_q    <= 1'b0;
            exp_val_q   <= 32'd0;
            cycle_cnt   <= 32'd0;
            branch_cnt  <= 32'd0;
            result      <= 32'd0;
            stable_cnt  <= '0;
            seen_q      <= 1'b0;
            last_pc     <= 32'd0;
            wr_ptr      <= '0;
            trace_count <= '0;
        end else if (start_ok) begin
            exp_en_q    <= expect_en;
            exp_val_q   <= expect_val;
            cycle_cnt   <= 32'd0;
            branch_cnt  <= 32'd0;
            result      <= 32'd0;
            stable_cnt  <= '0;
            seen_q      <= 1'b0;
            wr_ptr      <= '0;
            trace_count <= '0;
        end else if (sample) begin
            cycle_cnt  <= cycle_next;
            if ((cpu.instr[6:0] == OPC_BRANCH) && (branch_cnt != 32'hFFFF_FFFF)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            stable_cnt <= stable_next;
            seen_q     <= 1'b1;
            last_pc    <= cpu.pc;
            if (new_pc) begin
                wr_ptr <= wr_ptr + TW'(1);
                if (trace_count != DEPTH_MAX) begin
                    trace_count <= trace_count + (TW+1)'(1);
                end
            end
            if (halt) begin
                result <= cpu.reg_data;
            end
        end
    end

    // Trace storage; contents need no reset since trace_count gates readback
    always_ff @(posedge clk) begin
        if (!rst && !start_ok && sample && new_pc) begin
            mem_pc[wr_ptr]    <= cpu.pc;
            mem_instr[wr_ptr] <= cpu.instr;
        end
    end

    // Readback: index 0 is the slot just behind the write pointer
    always_comb begin
        rd_ptr      = wr_ptr - TW'(1) - trace_idx;
        trace_pc    = 32'd0;
        trace_instr = 32'd0;
        if ({1'b0, trace_idx} < trace_count) begin
            trace_pc    = mem_pc[rd_ptr];
            trace_instr = mem_instr[rd_ptr];
        end
    end

endmodule

// File: tb/tb_sr_trace_monitor.sv
// tb_sr_trace_monitor
// Directed self-checking bench for sr_trace_monitor with default parameters
// (TIMEOUT_CYCLES=120, HALT_REPEAT=4, TRACE_DEPTH=8). Inputs are driven just
// after the rising edge and outputs are sampled there as well, so each step
// shows the effect of the previous edge.
module tb_sr_trace_monitor;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BRANCH = 32'h0000_0063;

    logic        clk;
    logic        rst;
    logic        start;
    logic        expect_en;
    logic [31:0] expect_val;
    logic [2:0]  dut_state;
    logic        done;
    logic [31:0] cycle_cnt;
    logic [31:0] branch_cnt;
    logic [31:0] result;
    logic [2:0]  trace_idx;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic [3:0]  trace_count;

    int asserts  = 0;
    int failures = 0;

    sr_trace_monitor_if mon_bus ();

    sr_trace_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .expect_en   (expect_en),
        .expect_val  (expect_val),
        .cpu         (mon_bus.slave),
        .state       (dut_state),
        .done        (done),
        .cycle_cnt   (cycle_cnt),
        .branch_cnt  (branch_cnt),
        .result      (result),
        .trace_idx   (trace_idx),
        .trace_pc    (trace_pc),
        .trace_instr (trace_instr),
        .trace_count (trace_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the clock stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return NOP | (p << 12);
    endfunction

    // One clock of retire-stream stimulus, leaving time at edge+1
    task automatic step(input logic v, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] r);
        mon_bus.valid    = v;
        mon_bus.pc       = p;
        mon_bus.instr    = i;
        mon_bus.reg_data = r;
        @(posedge clk);
        #1;
    endtask

    // Start a run; a valid sample on the start cycle must be ignored
    task automatic do_start(input logic en, input logic [31:0] val);
        start      = 1'b1;
        expect_en  = en;
        expect_val = val;
        step(1'b1, 32'h100, NOP, 32'd0);
        start      = 1'b0;
    endtask

    task automatic run_halt_stream(input logic [31:0] rd);
        step(1'b1, 32'h0, instr_of(32'h0), rd);
        step(1'b1, 32'h4, instr_of(32'h4), rd);
        step(1'b1, 32'h8, instr_of(32'h8), rd);
        for (int k = 0; k < 4; k++) step(1'b1, 32'hC, instr_of(32'hC), rd);
    endtask

    task automatic test_reset;
        asserts++;
        if (dut_state !== 3'd0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: got state=%0d done=%0d expected 0/0", dut_state, done);
        end
        do_start(1'b0, 32'd0);
        asserts++;
        if (cycle_cnt !== 32'd0 || dut_state !== 3'd1) begin
            failures++;
            $display("[TB] FAIL start_cycle_ignored: got cnt=%0d state=%0d expected 0/1", cycle_cnt, dut_state);
        end
        step(1'b1, 32'h0, NOP, 32'd0);
        step(1'b1, 32'h4, NOP, 32'd0);
        step(1'b1, 32'h8, NOP, 32'd0);
        asserts++;
        if (cycle_cnt !== 32'd3 || trace_count !== 4'd3) begin
            failures++;
            $display("[TB] FAIL midrun_counts: got cnt=%0d tc=%0d expected 3/3", cycle_cnt, trace_count);
        end
        rst   = 1'b1;
        start = 1'b1;
        step(1'b1, 32'hC, NOP, 32'd0);
        start = 1'b0;
        step(1'b1, 32'h10, NOP, 32'd0);
        rst = 1'b0;
        asserts++;
        if (dut_state !== 3'd0 || done !== 1'b0 || cycle_cnt !== 32'd0 || trace_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset: got state=%0d done=%0d cnt=%0d tc=%0d expected 0/0/0/0",
                     dut_state, done, cycle_cnt, trace_count);
        end
        step(1'b1, 32'h14, NOP, 32'd0);
        step(1'b1, 32'h18, NOP, 32'd0);
        asserts++;
        if (dut_state !== 3'd0 || cycle_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL idle_no_count: got state=%0d cnt=%0d expected 0/0", dut_state, cycle_cnt);
        end
    endtask

    task automatic test_halt_pass;
        do_start(1'b1, 32'd5);
        step(1'b1, 32'h0, instr_of(32'h0), 32'd5);
        step(1'b1, 32'h4, instr_of(32'h4), 32'd5);
        step(1'b1, 32'h8, instr_of(32'h8), 32'd5);
        for (int k = 0; k < 3; k++) step(1'b1, 32'hC, instr_of(32'hC), 32'd5);
        asserts++;
        if (dut_state !== 3'd1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pre_halt: got state=%0d done=%0d expected 1/0", dut_state, done);
        end
        step(1'b1, 32'hC, instr_of(32'hC), 32'd5);
        asserts++;
        if (dut_state !== 3'd2 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pass_state: got state=%0d done=%0d expected 2/1", dut_state, done);
        end
        asserts++;
        if (cycle_cnt !== 32'd7 || result !== 32'd5 || trace_count !== 4'd4 || branch_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL pass_counts: got cnt=%0d res=%0d tc=%0d br=%0d expected 7/5/4/0",
                     cycle_cnt, result, trace_count, branch_cnt);
        end
        trace_idx = 3'd0; #1;
        asserts++;
        if (trace_pc !== 32'hC) begin
            failures++;
            $display("[TB] FAIL pass_idx0: got pc=%h expected 0000000c", trace_pc);
        end
        trace_idx = 3'd3; #1;
        asserts++;
        if (trace_pc !== 32'h0 || trace_instr !== instr_of(32'h0)) begin
            failures++;
            $display("[TB] FAIL pass_idx3: got pc=%h instr=%h expected 0/%h", trace_pc, trace_instr, instr_of(32'h0));
        end
        step(1'b1, 32'hC, instr_of(32'hC), 32'd9);
        trace_idx = 3'd1; #1;
        asserts++;
        if (trace_instr !== instr_of(32'h8)) begin
            failures++;
            $display("[TB] FAIL pass_idx1_instr: got %h expected %h", trace_instr, instr_of(32'h8));
        end
        trace_idx = 3'd4; #1;
        asserts++;
        if (trace_pc !== 32'd0 || trace_instr !== 32'd0) begin
            failures++;
            $display("[TB] FAIL pass_idx_beyond: got pc=%h instr=%h expected 0/0", trace_pc, trace_instr);
        end
        trace_idx = 3'd0;
        step(1'b1, 32'h40, instr_of(32'h40), 32'd9);
        asserts++;
        if (dut_state !== 3'd2 || cycle_cnt !== 32'd7 || result !== 32'd5 || trace_count !== 4'd4) begin
            failures++;
            $display("[TB] FAIL pass_hold: got state=%0d cnt=%0d res=%0d tc=%0d expected 2/7/5/4",
                     dut_state, cycle_cnt, result, trace_count);
        end
    endtask

    task automatic test_halt_fail;
        do_start(1'b1, 32'd6);
        asserts++;
        if (dut_state !== 3'd1 || cycle_cnt !== 32'd0 || result !== 32'd0 || trace_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL restart_clear: got state=%0d cnt=%0d res=%0d tc=%0d expected 1/0/0/0",
                     dut_state, cycle_cnt, result, trace_count);
        end
        run_halt_stream(32'd5);
        asserts++;
        if (dut_state !== 3'd3 || result !== 32'd5 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fail_state: got state=%0d res=%0d done=%0d expected 3/5/1", dut_state, result, done);
        end
        do_start(1'b0, 32'd6);
        run_halt_stream(32'd5);
        asserts++;
        if (dut_state !== 3'd2 || result !== 32'd5) begin
            failures++;
            $display("[TB] FAIL noexpect_state: got state=%0d res=%0d expected 2/5", dut_state, result);
        end
    endtask

    task automatic test_timeout;
        do_start(1'b1, 32'd1);
        for (int i = 0; i < 120; i++) begin
            if (i[0]) step(1'b1, 32'h4, BRANCH, 32'd7);
            else      step(1'b1, 32'h0, NOP, 32'd7);
            if (i == 118) begin
                asserts++;
                if (dut_state !== 3'd1 || cycle_cnt !== 32'd119) begin
                    failures++;
                    $display("[TB] FAIL pre_timeout: got state=%0d cnt=%0d expected 1/119", dut_state, cycle_cnt);
                end
            end
        end
        asserts++;
        if (dut_state !== 3'd4 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_state: got state=%0d done=%0d expected 4/1", dut_state, done);
        end
        asserts++;
        if (cycle_cnt !== 32'd120 || branch_cnt !== 32'd60 || result !== 32'd0 || trace_count !== 4'd8) begin
            failures++;
            $display("[TB] FAIL timeout_counts: got cnt=%0d br=%0d res=%0d tc=%0d expected 120/60/0/8",
                     cycle_cnt, branch_cnt, result, trace_count);
        end
        for (int k = 0; k < 5; k++) step(1'b1, 32'h4, BRANCH, 32'd7);
        trace_idx = 3'd0; #1;
        asserts++;
        if (dut_state !== 3'd4 || cycle_cnt !== 32'd120 || branch_cnt !== 32'd60 || trace_pc !== 32'h4) begin
            failures++;
            $display("[TB] FAIL timeout_hold: got state=%0d cnt=%0d br=%0d pc0=%h expected 4/120/60/4",
                     dut_state, cycle_cnt, branch_cnt, trace_pc);
        end
    endtask

    task automatic test_wrap;
        do_start(1'b0, 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 32'(i * 4), instr_of(32'(i * 4)), 32'd3);
        for (int k = 0; k < 3; k++) step(1'b1, 32'h2C, instr_of(32'h2C), 32'd3);
        trace_idx = 3'd0; #1;
        asserts++;
        if (dut_state !== 3'd2 || cycle_cnt !== 32'd15 || trace_count !== 4'd8 || trace_pc !== 32'h2C) begin
            failures++;
            $display("[TB] FAIL wrap_idx0: got state=%0d cnt=%0d tc=%0d pc=%h expected 2/15/8/2c",
                     dut_state, cycle_cnt, trace_count, trace_pc);
        end
        trace_idx = 3'd7; #1;
        asserts++;
        if (trace_pc !== 32'h10 || trace_instr !== instr_of(32'h10)) begin
            failures++;
            $display("[TB] FAIL wrap_idx7: got pc=%h instr=%h expected 10/%h", trace_pc, trace_instr, instr_of(32'h10));
        end
        trace_idx = 3'd0;
    endtask

    task automatic test_gap;
        do_start(1'b1, 32'd5);
        step(1'b1, 32'h0, NOP, 32'd5);
        step(1'b1, 32'hC, NOP, 32'd5);
        step(1'b1, 32'hC, NOP, 32'd5);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h99, NOP, 32'd8);
        asserts++;
        if (dut_state !== 3'd1 || cycle_cnt !== 32'd3) begin
            failures++;
            $display("[TB] FAIL gap_hold: got state=%0d cnt=%0d expected 1/3", dut_state, cycle_cnt);
        end
        step(1'b1, 32'hC, NOP, 32'd5);
        step(1'b1, 32'hC, NOP, 32'd5);
        asserts++;
        if (dut_state !== 3'd2 || cycle_cnt !== 32'd5 || result !== 32'd5) begin
            failures++;
            $display("[TB] FAIL gap_halt: got state=%0d cnt=%0d res=%0d expected 2/5/5", dut_state, cycle_cnt, result);
        end
    endtask

    task automatic test_halt_at_limit;
        do_start(1'b1, 32'd9);
        for (int i = 0; i < 116; i++) begin
            if (i[0]) step(1'b1, 32'h4, NOP, 32'd9);
            else      step(1'b1, 32'h0, NOP, 32'd9);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 32'h8, NOP, 32'd9);
        asserts++;
        if (dut_state !== 3'd1 || cycle_cnt !== 32'd119) begin
            failures++;
            $display("[TB] FAIL limit_pre: got state=%0d cnt=%0d expected 1/119", dut_state, cycle_cnt);
        end
        step(1'b1, 32'h8, NOP, 32'd9);
        asserts++;
        if (dut_state !== 3'd2 || cycle_cnt !== 32'd120 || result !== 32'd9) begin
            failures++;
            $display("[TB] FAIL limit_halt_wins: got state=%0d cnt=%0d res=%0d expected 2/120/9",
                     dut_state, cycle_cnt, result);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        expect_en  = 1'b0;
        expect_val = 32'd0;
        trace_idx  = 3'd0;
        step(1'b0, 32'd0, NOP, 32'd0);
        step(1'b0, 32'd0, NOP, 32'd0);
        rst = 1'b0;
        test_reset();
        test_halt_pass();
        test_halt_fail();
        test_timeout();
        test_wrap();
        test_gap();
        test_halt_at_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/sr_trace_monitor.md
# sr_trace_monitor

Synthesizable run monitor for the schoolRISCV core. It replaces the testbench-only cycle print, timeout and `$stop` with hardware that can sit beside `sm_top` in simulation or on an FPGA. It watches the retiring `pc`/`instr` stream and counts cycles and branches. It detects program halt (a self-loop) and checks the watched register (normally a0) against an expected value. It raises TIMEOUT if the program never halts, and keeps a circular buffer of the last distinct instructions for post-mortem readback.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 120: valid cycles in RUN before TIMEOUT; ≥ 1.
- `HALT_REPEAT`, 4: consecutive valid cycles at an identical pc that declare halt; ≥ 2.
- `TRACE_DEPTH`, 8: trace buffer entries; power of two, ≥ 2.
- `TW`, $clog2(TRACE_DEPTH): trace index width (derived).

Ports:
- `clk`  in  1: single clock. One clock; every flop is clocked on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: begins a run (IDLE or terminal states); ignored in RUN.
- `valid`  in  1: CPU advanced this cycle (core clock enable); the monitor samples inputs only when high.
- `pc`  in  32: current pc.
- `instr`  in  32: current instruction.
- `reg_data`  in  32: watched register value.
- `expect_en`  in  1: enable result check; sampled with `start`.
- `expect_val`  in  32: expected result; sampled with `start`.
- `state`  out  3: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT.
- `done`  out  1: high in PASS, FAIL or TIMEOUT.
- `cycle_cnt`  out  32: valid cycles in the current or last run.
- `branch_cnt`  out  32: valid cycles with `instr[6:0]` = 7'b1100011.
- `result`  out  32: `reg_data` captured on the halting cycle.
- `trace_idx`  in  TW: readback index; 0 is the most recent entry.
- `trace_pc`  out  32: pc of the selected entry.
- `trace_instr`  out  32: instr of the selected entry.
- `trace_count`  out  TW+1: number of valid entries, saturating at TRACE_DEPTH.

## Operation

- Reset: `state` is IDLE. All counters, `result`, the trace write pointer and `trace_count` are 0, so `done` is 0. Trace storage contents are don't-care. A run in progress is abandoned.
- `start` in IDLE/PASS/FAIL/TIMEOUT:
  - Latch `expect_en`/`expect_val`.
  - Clear `cycle_cnt`, `branch_cnt`, `result`, the stable counter, `trace_count` and the write pointer.
  - Go to RUN.
  - `valid` in the same cycle as `start` is not counted.
- RUN, valid cycle:
  - Increment `cycle_cnt`. Increment `branch_cnt` if the opcode is branch. Both counters saturate at 2^32-1.
  - Stable counter: set to 1 if this is the first valid cycle of the run or `pc` ≠ the last sampled pc; otherwise increment, saturating at HALT_REPEAT.
  - Trace: write {pc, instr} at the write pointer only when the stable counter is set to 1 (new pc). The pointer wraps modulo TRACE_DEPTH, and `trace_count` increments, saturating at TRACE_DEPTH.
  - Halt: the stable counter reaches HALT_REPEAT on this cycle. Capture `result` = `reg_data`. Go to PASS if `!expect_en` or `reg_data` == latched value, else FAIL.
  - Timeout: the incremented `cycle_cnt` equals TIMEOUT_CYCLES and no halt occurs this cycle. Go to TIMEOUT; `result` is unchanged.
  - Halt and timeout in the same cycle: halt wins (PASS/FAIL).
- RUN, `valid` low: no state changes and no counting. Gaps do not break the pc-stable streak.
- Terminal states hold all outputs and freeze the trace until `rst` or `start`.
- Trace readback (combinational mux of registered storage): entry `trace_idx` = the write that is `trace_idx`+1 writes behind the pointer. Indices ≥ `trace_count` return 0.

## Timing

- `state`, `done`, counters and `result` are registered. They update on the edge that samples the triggering valid cycle and are visible in the next cycle.
- Latency from halting valid cycle to `done`: 1 clock.
- `trace_pc`/`trace_instr` follow `trace_idx` in the same cycle, with no added latency. A write on edge N is visible at index 0 after edge N.
- `rst` dominates `start` in the same cycle.

## Test plan

- Reset: assert `rst` 2 cycles mid-run → `state`=0, `done`=0, `cycle_cnt`=0, `trace_count`=0. Then deassert, and `start` is required before counting.
- Halt PASS (HALT_REPEAT=4): `expect_val`=5, `valid` every cycle, pc 0,4,8,C,C,C,C, `reg_data`=5 → PASS one cycle after the 7th valid cycle. Expect `cycle_cnt`=7, `result`=5, `trace_count`=4, idx0 pc=C, idx3 pc=0.
- Halt FAIL: same stream with `expect_val`=6 → `state`=3 and `result`=5. With `expect_en`=0 the same stream gives `state`=2.
- Timeout: pc alternates 0,4 forever, with branch instr at 4 → TIMEOUT after the 120th valid cycle. Expect `cycle_cnt`=120, `branch_cnt`=60, `result`=0, and stable inputs afterward change nothing.
- Wrap: 12 distinct pcs 0..2C then halt at 2C (TRACE_DEPTH=8) → `trace_count`=8, idx0 pc=2C, idx7 pc=10.
- Corners:
  - `valid` low for 3 cycles inside the halt streak still halts after 4 valid repeats.
  - Halt on valid cycle 120 gives PASS, not TIMEOUT.
  - `start` in PASS restarts with cleared counters.
